ps2_key_state_tracker: RTL and testbench
========================================

// Module: ps2_key_state_tracker
// PURPOSE
//  Consumes the byte stream from the PS/2 byte receiver (one strobe per received scancode byte).
//  Decodes set-2 make/break/extended prefixes into a held-key bitmap for both players.
//  Keys stay asserted while held and clear on their own break code.
//  Outputs feed the game/player-control logic as level signals (p1keys / p2keys).
// PARAMETERS
//  PREFIX_TIMEOUT  1_000_000  clk cycles allowed between a prefix byte and its follower before abort
//  TO_W            20         width of timeout counter; must hold PREFIX_TIMEOUT
//  EXT_ALIAS       1          1: arrow codes accepted without E0 (numpad aliases); 0: arrows need E0
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  code_valid  in   1  one-cycle strobe: code holds a new scancode byte
//  code        in   8  scancode byte, valid only while code_valid=1
//  p1keys      out  5  P1 held keys: [0]up [1]left [2]right [3]down [4]fire
//  p2keys      out  5  P2 held keys, same bit order
//  key_event   out  1  one-cycle pulse: p1keys or p2keys changed this cycle
//  proto_err   out  1  one-cycle pulse: prefix timeout or illegal prefix order
// BEHAVIOUR
//  Reset (async, rst_n=0): p1keys=0, p2keys=0, key_event=0, proto_err=0, FSM=IDLE, counters=0.
//  All outputs are registered. The bitmap updates on the clk edge after the strobe of the final byte (latency 1).
//  Key map (code -> bit):
//   - P1: 75 up, 6B left, 74 right, 72 down, 29 space=fire.
//   - P2: 1D W=up, 1C A=left, 23 D=right, 1B S=down, 0D tab=fire.
//   - Arrows (75,6B,74,72) are honoured after E0, or bare when EXT_ALIAS=1.
//   - E0 followed by any non-arrow code: ignored.
//   - Unmapped codes: ignored; no bitmap change.
//  FSM states and transitions:
//   - IDLE:
//     - E0 -> EXT.
//     - F0 -> BRK.
//     - E1 -> SKIP, skip count = 7.
//     - AA, FC, FE, 00, FF (BAT/err/overrun) -> clear both bitmaps; stay IDLE.
//     - Any other code -> make: set its bit.
//   - EXT:
//     - F0 -> EXT_BRK.
//     - Any other code -> extended make; -> IDLE.
//   - BRK:
//     - Any code except E0/E1/F0 -> break: clear its bit; -> IDLE.
//     - E0/E1/F0 -> proto_err; -> IDLE; byte dropped.
//   - EXT_BRK:
//     - Any non-prefix code -> extended break; -> IDLE.
//     - Prefix byte -> proto_err; -> IDLE.
//   - SKIP (Pause sequence):
//     - Each strobe decrements the count; no bitmap change.
//     - Count reaches 0 -> IDLE.
//  Timeout:
//   - Counter resets on every strobe and counts only in EXT, BRK, EXT_BRK, SKIP.
//   - Reaching PREFIX_TIMEOUT -> proto_err pulse, FSM -> IDLE, bitmaps unchanged.
//   - Counter saturates at PREFIX_TIMEOUT; it never wraps.
//  Make of an already-set bit, or break of an already-clear bit: no change, no key_event.
//  Multiple keys may be held together, including opposing directions; no arbitration here.
//  key_event = registered (new bitmap != old bitmap); never asserts on the reset-release cycle.
//  Simultaneous timeout and strobe in the same cycle: the strobe wins.
//   - The byte is processed in the current state; no proto_err.
//  code is ignored while code_valid=0.
//  rst_n assertion mid-sequence aborts immediately: FSM=IDLE and bitmaps clear asynchronously.
// TESTING
//  1. Reset, then release with no strobes -> p1keys=0, p2keys=0, key_event=0, proto_err=0.
//  2. Strobe E0,75 -> p1keys=5'b00001 one cycle after the 75 strobe, with a key_event pulse.
//     Then E0,F0,75 -> p1keys=0 and key_event again.
//  3. Strobe 1D then 23 -> p2keys=5'b00101.
//     Then F0,1D -> p2keys=5'b00100; p1keys stays 0 throughout.
//  4. Strobe F0, then idle PREFIX_TIMEOUT cycles -> proto_err pulse once, FSM IDLE.
//     Then 29 -> p1keys=5'b10000 (make, not break).
//  5. With p1keys=5'b10000: strobe E1,14,77,E1,F0,14,F0,77 -> no change, no key_event.
//     Then AA -> p1keys=0 with key_event.
//  6. EXT_ALIAS=0: bare 75 -> no change.
//     Then E0, and assert rst_n mid-sequence before the follower -> outputs 0 at once.
//     After release, 75 alone -> still 0.

Source files
------------

// File: rtl/ps2_key_state_tracker.sv
// ps2_key_state_tracker
//   Turns the PS/2 set-2 scancode byte stream into two 5-bit held-key
//   bitmaps, one per player. Make codes set a bit and break codes clear it.
//   E0 (extended), F0 (break) and E1 (Pause) prefixes are tracked by a
//   small FSM. An abandoned prefix is aborted by a timeout that pulses
//   proto_err.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   code_valid in   one-cycle strobe, code holds a new byte
//   code[7:0]  in   scancode byte
//   p1keys[4:0] out P1 held keys [0]up [1]left [2]right [3]down [4]fire
//   p2keys[4:0] out P2 held keys, same order
//   key_event  out  pulse: either bitmap changed on this edge
//   proto_err  out  pulse: prefix timeout or illegal prefix order
module ps2_key_state_tracker #(
    parameter int PREFIX_TIMEOUT = 1_000_000,
    parameter int TO_W           = 20,
    parameter bit EXT_ALIAS      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [4:0] p1keys,
    output logic [4:0] p2keys,
    output logic       key_event,
    output logic       proto_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    // The key map, indexed by bitmap bit. The entry at index 0 is the rightmost value.
    localparam logic [4:0][7:0] P1_CODES = {8'h29, 8'h72, 8'h74, 8'h6B, 8'h75};
    localparam logic [4:0][7:0] P2_CODES = {8'h0D, 8'h1B, 8'h23, 8'h1C, 8'h1D};

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(PREFIX_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

    state_t          state_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [2:0]      skip_cnt_reg;
    logic [4:0]      p1_reg;
    logic [4:0]      p2_reg;
    logic            key_event_reg;
    logic            proto_err_reg;

    logic [4:0] p1_next;
    logic [4:0] p2_next;
    logic [4:0] p1_hit;
    logic [4:0] p2_hit;
    logic       ext_ctx;
    logic       arrow_ok;
    logic       is_prefix;
    logic       is_clear_code;

    assign ext_ctx   = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
    // Arrows also arrive without E0 as numpad aliases. EXT_ALIAS decides if those count.
    assign arrow_ok  = ext_ctx || EXT_ALIAS;
    assign is_prefix = (code == 8'hE0) || (code == 8'hE1) || (code == 8'hF0);
    // BAT completion, error and overrun bytes mean the keyboard state is unknown.
    assign is_clear_code = (code == 8'hAA) || (code == 8'hFC) || (code == 8'hFE) ||
                           (code == 8'h00) || (code == 8'hFF);

    // Per-bit code match. Only the arrows (bits 0..3 of P1) exist in the
    // extended space. Fire and all P2 keys are plain codes only.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_map
            if (gi < 4) begin : g_arrow
                assign p1_hit[gi] = (code == P1_CODES[gi]) && arrow_ok;
            end else begin : g_plain
                assign p1_hit[gi] = (code == P1_CODES[gi]) && !ext_ctx;
            end
            assign p2_hit[gi] = (code == P2_CODES[gi]) && !ext_ctx;
        end
    endgenerate

    // Next bitmaps. A make sets bits and a break clears them. Prefix bytes
    // and SKIP bytes leave the bitmaps untouched.
    always_comb begin
        p1_next = p1_reg;
        p2_next = p2_reg;
        if (code_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_clear_code) begin
                        p1_next = '0;
                        p2_next = '0;
                    end else if (!is_prefix) begin
                        p1_next = p1_reg | p1_hit;
                        p2_next = p2_reg | p2_hit;
                    end
                end
                ST_EXT: begin
                    if (code != 8'hF0) begin
                        p1_next = p1_reg | p1_hit;
                        p2_next = p2_reg | p2_hit;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (!is_prefix) begin
                        p1_next = p1_reg & ~p1_hit;
                        p2_next = p2_reg & ~p2_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            to_cnt_reg    <= '0;
            skip_cnt_reg  <= '0;
            p1_reg        <= '0;
            p2_reg        <= '0;
            key_event_reg <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            p1_reg        <= p1_next;
            p2_reg        <= p2_next;
            key_event_reg <= (p1_next != p1_reg) || (p2_next != p2_reg);
            proto_err_reg <= 1'b0;

            if (code_valid) begin
                // A strobe always restarts the prefix timer. It also wins over a timeout that expires on the same edge.
                to_cnt_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (code == 8'hE0) begin
                            state_reg <= ST_EXT;
                        end else if (code == 8'hF0) begin
                            state_reg <= ST_BRK;
                        end else if (code == 8'hE1) begin
                            state_reg    <= ST_SKIP;
                            skip_cnt_reg <= 3'd7;
                        end
                    end
                    ST_EXT: begin
                        state_reg <= (code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        if (is_prefix) begin
                            proto_err_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_cnt_reg <= skip_cnt_reg - 3'd1;
                        if (skip_cnt_reg == 3'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end else if (state_reg != ST_IDLE) begin
                if (to_cnt_reg == TO_LAST) begin
                    proto_err_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                    skip_cnt_reg  <= '0;
                    to_cnt_reg    <= TO_MAX;
                end else if (to_cnt_reg < TO_MAX) begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign p1keys    = p1_reg;
    assign p2keys    = p2_reg;
    assign key_event = key_event_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
module tb_ps2_key_state_tracker;

    localparam int PT = 16;

    logic       clk;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code;
    logic [4:0] p1keys, p2keys, p1keys_a0, p2keys_a0;
    logic       key_event, proto_err, key_event_a0, proto_err_a0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] p1;
        logic [4:0] p2;
        logic       ev;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        logic [4:0] p1;
        logic [4:0] p2;
        logic       ev;
        logic       err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    ps2_key_state_tracker #(.PREFIX_TIMEOUT(PT), .TO_W(5), .EXT_ALIAS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .p1keys(p1keys), .p2keys(p2keys), .key_event(key_event), .proto_err(proto_err)
    );

    ps2_key_state_tracker #(.PREFIX_TIMEOUT(PT), .TO_W(5), .EXT_ALIAS(1'b0)) dut_a0 (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .p1keys(p1keys_a0), .p2keys(p2keys_a0), .key_event(key_event_a0), .proto_err(proto_err_a0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [4:0] p1, input logic [4:0] p2,
                           input logic ev, input logic err);
        chk({nm, ".p1"},  8'(p1keys),    8'(p1));
        chk({nm, ".p2"},  8'(p2keys),    8'(p2));
        chk({nm, ".ev"},  8'(key_event), 8'(ev));
        chk({nm, ".err"}, 8'(proto_err), 8'(err));
    endtask

    // Drive one strobe. Queue the expected outputs, then pop them and compare once the DUT's output edge has passed.
    task automatic send(input logic [7:0] c, input logic [4:0] p1, input logic [4:0] p2,
                        input logic ev, input logic err);
        exp_t e;
        e.p1 = p1; e.p2 = p2; e.ev = ev; e.err = err;
        exp_q.push_back(e);
        code_valid = 1'b1;
        code       = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'($urandom);
        e = exp_q.pop_front();
        chk_all($sformatf("byte %h", c), e.p1, e.p2, e.ev, e.err);
        $display("byte %h -> p1=%b p2=%b ev=%b err=%b", c, p1keys, p2keys, key_event, proto_err);
    endtask

    function automatic void add(input logic [7:0] c, input logic [4:0] p1, input logic [4:0] p2,
                                input logic ev, input logic err);
        vec_t v;
        v.code = c; v.p1 = p1; v.p2 = p2; v.ev = ev; v.err = err;
        vecs.push_back(v);
    endfunction

    initial begin
        int pulses;
        int pulse_at;

        // Vector table: byte -> expected bitmaps/pulses one edge later (EXT_ALIAS=1 DUT)
        add(8'hE0, 5'b00000, 5'b00000, 0, 0);
        add(8'h75, 5'b00001, 5'b00000, 1, 0);
        add(8'hE0, 5'b00001, 5'b00000, 0, 0);
        add(8'hF0, 5'b00001, 5'b00000, 0, 0);
        add(8'h75, 5'b00000, 5'b00000, 1, 0);
        add(8'h1D, 5'b00000, 5'b00001, 1, 0);
        add(8'h23, 5'b00000, 5'b00101, 1, 0);
        add(8'hF0, 5'b00000, 5'b00101, 0, 0);
        add(8'h1D, 5'b00000, 5'b00100, 1, 0);
        add(8'h23, 5'b00000, 5'b00100, 0, 0);  // make of held key
        add(8'hF0, 5'b00000, 5'b00100, 0, 0);
        add(8'h1C, 5'b00000, 5'b00100, 0, 0);  // break of released key
        add(8'h6B, 5'b00010, 5'b00100, 1, 0);  // bare arrow alias
        add(8'hE0, 5'b00010, 5'b00100, 0, 0);
        add(8'h29, 5'b00010, 5'b00100, 0, 0);  // E0 + non-arrow ignored
        add(8'h74, 5'b00110, 5'b00100, 1, 0);
        add(8'h72, 5'b01110, 5'b00100, 1, 0);
        add(8'hF0, 5'b01110, 5'b00100, 0, 0);
        add(8'hF0, 5'b01110, 5'b00100, 0, 1);  // F0 F0 illegal
        add(8'hF0, 5'b01110, 5'b00100, 0, 0);
        add(8'hE0, 5'b01110, 5'b00100, 0, 1);  // F0 E0 illegal
        add(8'hE0, 5'b01110, 5'b00100, 0, 0);
        add(8'hF0, 5'b01110, 5'b00100, 0, 0);
        add(8'hE0, 5'b01110, 5'b00100, 0, 1);  // E0 F0 E0 illegal
        add(8'hF0, 5'b01110, 5'b00100, 0, 0);
        add(8'h6B, 5'b01100, 5'b00100, 1, 0);
        add(8'hE0, 5'b01100, 5'b00100, 0, 0);
        add(8'hF0, 5'b01100, 5'b00100, 0, 0);
        add(8'h72, 5'b00100, 5'b00100, 1, 0);  // extended break
        add(8'hE0, 5'b00100, 5'b00100, 0, 0);
        add(8'h1D, 5'b00100, 5'b00100, 0, 0);  // E0 + P2 code ignored
        add(8'hFE, 5'b00000, 5'b00000, 1, 0);  // resend -> clear all
        add(8'h00, 5'b00000, 5'b00000, 0, 0);
        add(8'h29, 5'b10000, 5'b00000, 1, 0);
        add(8'hE1, 5'b10000, 5'b00000, 0, 0);  // Pause sequence skipped
        add(8'h14, 5'b10000, 5'b00000, 0, 0);
        add(8'h77, 5'b10000, 5'b00000, 0, 0);
        add(8'hE1, 5'b10000, 5'b00000, 0, 0);
        add(8'hF0, 5'b10000, 5'b00000, 0, 0);
        add(8'h14, 5'b10000, 5'b00000, 0, 0);
        add(8'hF0, 5'b10000, 5'b00000, 0, 0);
        add(8'h77, 5'b10000, 5'b00000, 0, 0);
        add(8'h75, 5'b10001, 5'b00000, 1, 0);  // back in IDLE right after skip
        add(8'hAA, 5'b00000, 5'b00000, 1, 0);
        add(8'hFF, 5'b00000, 5'b00000, 0, 0);

        rst_n      = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", 5'b0, 5'b0, 0, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all("after_release", 5'b0, 5'b0, 0, 0);
        end

        foreach (vecs[i])
            send(vecs[i].code, vecs[i].p1, vecs[i].p2, vecs[i].ev, vecs[i].err);

        // code must be ignored while code_valid is low
        code = 8'h75;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all("no_strobe", 5'b0, 5'b0, 0, 0);
        end

        // key_event lasts exactly one cycle
        send(8'h29, 5'b10000, 5'b0, 1, 0);
        @(posedge clk);
        #1;
        chk_all("ev_drop", 5'b10000, 5'b0, 0, 0);
        send(8'hFC, 5'b00000, 5'b0, 1, 0);

        // Prefix timeout: a single proto_err pulse on the PT-th idle edge
        send(8'hF0, 5'b0, 5'b0, 0, 0);
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= PT + 4; i++) begin
            @(posedge clk);
            #1;
            if (proto_err) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("timeout_pulses", 8'(pulses), 8'd1);
        chk("timeout_edge", 8'(pulse_at), 8'(PT));
        send(8'h29, 5'b10000, 5'b0, 1, 0);  // make, not break

        // Strobe in the same cycle as the timeout: byte processed, no error
        send(8'hF0, 5'b10000, 5'b0, 0, 0);
        repeat (PT - 1) begin
            @(posedge clk);
            #1;
            chk("pre_timeout_err", 8'(proto_err), 8'd0);
        end
        send(8'h29, 5'b00000, 5'b0, 1, 0);
        repeat (PT + 2) begin
            @(posedge clk);
            #1;
            chk("post_race_err", 8'(proto_err), 8'd0);
        end

        // EXT_ALIAS=0 instance: bare arrows ignored, async reset mid-sequence
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h75, 5'b00001, 5'b0, 1, 0);
        chk("a0_bare_p1", 8'(p1keys_a0), 8'd0);
        chk("a0_bare_ev", 8'(key_event_a0), 8'd0);
        send(8'hE0, 5'b00001, 5'b0, 0, 0);
        send(8'h75, 5'b00001, 5'b0, 0, 0);
        chk("a0_ext_p1", 8'(p1keys_a0), 8'b00001);
        chk("a0_ext_ev", 8'(key_event_a0), 8'd1);
        send(8'hE0, 5'b00001, 5'b0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 5'b0, 5'b0, 0, 0);
        chk("async_rst_a0_p1", 8'(p1keys_a0), 8'd0);
        chk("async_rst_a0_p2", 8'(p2keys_a0), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h75, 5'b00001, 5'b0, 1, 0);  // dut was reset to IDLE: bare alias make
        chk("a0_after_rst_p1", 8'(p1keys_a0), 8'd0);
        chk("a0_after_rst_err", 8'(proto_err_a0), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
